// File: rtl/pipelined_divider_pkg.sv
// Shared types and constants for the pipelined signed-by-unsigned round divider.
package pipelined_divider_pkg;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_NEAREST = 1'b1;

  typedef struct packed {
    logic neg;   // dividend was negative
    logic mode;  // ROUND_TRUNC or ROUND_NEAREST
    logic dbz;   // divisor was zero
  } ctrl_t;

  function automatic int pipe_latency(input int dividend_width);
    return dividend_width + 2;
  endfunction

endpackage

// File: rtl/divider_stage.sv
// One restoring-division step: resolves quotient bit bit_index of |dividend|.
module divider_stage
  import pipelined_divider_pkg::*;
#(
  parameter int dividend_width = 12,
  parameter int divisor_width  = 6,
  parameter int tag_width      = 6,
  parameter int bit_index      = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      advance,
  input  logic                      in_valid,
  input  logic [dividend_width-1:0] in_rem,
  input  logic [dividend_width-1:0] in_quo,
  input  logic [divisor_width-1:0]  in_div,
  input  ctrl_t                     in_ctrl,
  input  logic [tag_width-1:0]      in_tag,
  output logic                      out_valid,
  output logic [dividend_width-1:0] out_rem,
  output logic [dividend_width-1:0] out_quo,
  output logic [divisor_width-1:0]  out_div,
  output ctrl_t                     out_ctrl,
  output logic [tag_width-1:0]      out_tag
);

  localparam int W  = dividend_width;
  localparam int XW = dividend_width + divisor_width;

  logic [XW-1:0]            shifted_div;
  logic                     fits;
  logic                     valid_d, valid_q;
  logic [W-1:0]             rem_d, rem_q, quo_d, quo_q;
  logic [divisor_width-1:0] div_d, div_q;
  ctrl_t                    ctrl_d, ctrl_q;
  logic [tag_width-1:0]     tag_d, tag_q;

  // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    shifted_div    = {{W{1'b0}}, in_div} << bit_index;
    fits           = {{divisor_width{1'b0}}, in_rem} >= shifted_div;
    valid_d        = in_valid;
    rem_d          = fits ? in_rem - shifted_div[W-1:0] : in_rem;
    quo_d          = in_quo;
    quo_d[bit_index] = fits;
    div_d          = in_div;
    ctrl_d         = in_ctrl;
    tag_d          = in_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_d;
    end
  end

  // NOTE: datapath registers are not reset; the valid bit alone qualifies their contents.
  always_ff @(posedge clock) begin
    if (advance) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      ctrl_q <= ctrl_d;
      tag_q  <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_rem   = rem_q;
  assign out_quo   = quo_q;
  assign out_div   = div_q;
  assign out_ctrl  = ctrl_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pipelined_round_divider.sv
// Fully pipelined signed/unsigned divider with rounding and valid/ready backpressure.
// Remainder output is built only when PIPELINED_ROUND_DIVIDER_REMAINDER_EN is defined.
module pipelined_round_divider
  import pipelined_divider_pkg::*;
#(
  parameter int dividend_width = 12,
  parameter int divisor_width  = 6,
  parameter int tag_width      = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [tag_width-1:0]      input_tag,
  input  logic                      round_mode,
  input  logic [divisor_width-1:0]  divisor,
  input  logic [dividend_width-1:0] dividend,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [tag_width-1:0]      output_tag,
  output logic [dividend_width-1:0] quotient,
  output logic [dividend_width-1:0] remainder,
  output logic                      div_by_zero
);

  localparam int W = dividend_width;
  localparam int D = divisor_width;
  localparam int T = tag_width;

  logic advance;

  // Stage-indexed pipeline; index 0 is the input register, index W the last restoring step.
  logic         valid_s [0:W];
  logic [W-1:0] rem_s   [0:W];
  logic [W-1:0] quo_s   [0:W];
  logic [D-1:0] div_s   [0:W];
  ctrl_t        ctrl_s  [0:W];
  logic [T-1:0] tag_s   [0:W];

  logic         valid0_d, valid0_q;
  logic [W-1:0] mag0_d, mag0_q;
  logic [D-1:0] div0_d, div0_q;
  ctrl_t        ctrl0_d, ctrl0_q;
  logic [T-1:0] tag0_d, tag0_q;

  assign advance     = !output_valid || output_ready;
  assign input_ready = advance;

  always_comb begin
    valid0_d     = input_valid;
    mag0_d       = dividend[W-1] ? -dividend : dividend;
    div0_d       = divisor;
    ctrl0_d.neg  = dividend[W-1];
    ctrl0_d.mode = round_mode ? ROUND_NEAREST : ROUND_TRUNC;
    ctrl0_d.dbz  = (divisor == '0);
    tag0_d       = input_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid0_q <= 1'b0;
    end else if (advance) begin
      valid0_q <= valid0_d;
    end
  end

  always_ff @(posedge clock) begin
    if (advance) begin
      mag0_q  <= mag0_d;
      div0_q  <= div0_d;
      ctrl0_q <= ctrl0_d;
      tag0_q  <= tag0_d;
    end
  end

  assign valid_s[0] = valid0_q;
  assign rem_s[0]   = mag0_q;
  assign quo_s[0]   = '0;
  assign div_s[0]   = div0_q;
  assign ctrl_s[0]  = ctrl0_q;
  assign tag_s[0]   = tag0_q;

  for (genvar k = 1; k <= W; k++) begin : g_stage
    divider_stage #(
      .dividend_width(W),
      .divisor_width (D),
      .tag_width     (T),
      .bit_index     (W - k)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .advance  (advance),
      .in_valid (valid_s[k-1]),
      .in_rem   (rem_s[k-1]),
      .in_quo   (quo_s[k-1]),
      .in_div   (div_s[k-1]),
      .in_ctrl  (ctrl_s[k-1]),
      .in_tag   (tag_s[k-1]),
      .out_valid(valid_s[k]),
      .out_rem  (rem_s[k]),
      .out_quo  (quo_s[k]),
      .out_div  (div_s[k]),
      .out_ctrl (ctrl_s[k]),
      .out_tag  (tag_s[k])
    );
  end

  logic         round_up;
  logic [W-1:0] q_mag;
  logic         output_valid_d, output_valid_q;
  logic [W-1:0] quotient_d, quotient_q;
  logic [T-1:0] output_tag_d, output_tag_q;
  logic         div_by_zero_d, div_by_zero_q;

  // A zero divisor leaves the magnitude untouched in rem_s[W], which becomes the remainder.
  always_comb begin
    round_up       = (ctrl_s[W].mode == ROUND_NEAREST) && !ctrl_s[W].dbz &&
                     ({rem_s[W], 1'b0} >= {{(W + 1 - D){1'b0}}, div_s[W]});
    q_mag          = quo_s[W] + {{(W - 1){1'b0}}, round_up};
    output_valid_d = valid_s[W];
    output_tag_d   = tag_s[W];
    div_by_zero_d  = ctrl_s[W].dbz;
    quotient_d     = ctrl_s[W].dbz ? '0 : (ctrl_s[W].neg ? -q_mag : q_mag);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      output_valid_q <= 1'b0;
      quotient_q     <= '0;
      output_tag_q   <= '0;
      div_by_zero_q  <= 1'b0;
    end else if (advance) begin
      output_valid_q <= output_valid_d;
      quotient_q     <= quotient_d;
      output_tag_q   <= output_tag_d;
      div_by_zero_q  <= div_by_zero_d;
    end
  end

  assign output_valid = output_valid_q;
  assign quotient     = quotient_q;
  assign output_tag   = output_tag_q;
  assign div_by_zero  = div_by_zero_q;

`ifdef PIPELINED_ROUND_DIVIDER_REMAINDER_EN
  logic [W-1:0] r_mag;
  logic [W-1:0] remainder_d, remainder_q;

  // Rounding up moves the quotient past the true value, so the remainder changes sign.
  always_comb begin
    r_mag       = round_up ? ({{(W - D){1'b0}}, div_s[W]} - rem_s[W]) : rem_s[W];
    remainder_d = (ctrl_s[W].neg ^ round_up) ? -r_mag : r_mag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      remainder_q <= '0;
    end else if (advance) begin
      remainder_q <= remainder_d;
    end
  end

  assign remainder = remainder_q;
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_pipelined_round_divider.sv
// Self-checking bench for pipelined_round_divider: directed cases, a stalled random stream and mid-stream reset.
module tb_pipelined_round_divider;

  localparam int W   = 12;
  localparam int D   = 6;
  localparam int T   = 6;
  localparam int LAT = 14;
`ifdef PIPELINED_ROUND_DIVIDER_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic [T-1:0] tag;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         input_valid;
  logic         input_ready;
  logic [T-1:0] input_tag;
  logic         round_mode;
  logic [D-1:0] divisor;
  logic [W-1:0] dividend;
  logic         output_valid;
  logic         output_ready;
  logic [T-1:0] output_tag;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   stall_seen = 0;

  pipelined_round_divider #(
    .dividend_width(W),
    .divisor_width (D),
    .tag_width     (T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_tag   (input_tag),
    .round_mode  (round_mode),
    .divisor     (divisor),
    .dividend    (dividend),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_tag  (output_tag),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int q, input int r, input bit dbz, input int tag);
    exp_t e;
    e.q   = W'(q);
    e.r   = REM_EN ? W'(r) : '0;
    e.dbz = dbz;
    e.tag = T'(tag);
    return e;
  endfunction

  // Reference model on integer magnitudes, independent of the restoring datapath.
  function automatic exp_t model(input int a, input int d, input bit mode, input int tag);
    int mag, qm, rm;
    bit flip;
    if (d == 0) return mk(0, a, 1'b1, tag);
    mag  = (a < 0) ? -a : a;
    qm   = mag / d;
    rm   = mag % d;
    flip = 1'b0;
    if (mode && (2 * rm >= d)) begin
      qm++;
      rm   = d - rm;
      flip = 1'b1;
    end
    return mk((a < 0) ? -qm : qm, ((a < 0) ^ flip) ? -rm : rm, 1'b0, tag);
  endfunction

  // Scoreboard: outputs sampled on the falling edge, i.e. the handshake the next rising edge sees.
  always @(negedge clock) begin
    if (!reset) begin
      if (output_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", output_valid, 0);
        end else begin
          if (!output_ready) begin
            stall_seen++;
            check("stall_input_ready", input_ready, 0);
          end
          check("quotient", quotient, sb[0].q);
          check("remainder", remainder, sb[0].r);
          check("div_by_zero", div_by_zero, sb[0].dbz);
          check("output_tag", output_tag, sb[0].tag);
          if (output_ready) void'(sb.pop_front());
        end
      end
      if (input_valid && input_ready) sb.push_back(cur_exp);
    end
  end

  // Called and returns at posedge+1; leaves input_valid high so calls chain back-to-back.
  task automatic send(input int a, input int d, input bit mode, input exp_t e);
    int waited = 0;
    input_valid = 1'b1;
    dividend    = W'(a);
    divisor     = D'(d);
    round_mode  = mode;
    input_tag   = e.tag;
    cur_exp     = e;
    @(negedge clock);
    while (!input_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!input_ready) check("accept_timeout", input_ready, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_rand(input int tag);
    int a, d;
    bit mode;
    a    = int'($urandom_range(0, 4095)) - 2048;
    d    = int'($urandom_range(0, 63));
    mode = 1'($urandom_range(0, 1));
    send(a, d, mode, model(a, d, mode, tag));
  endtask

  task automatic measure_latency(input string tag);
    int lat = 1;
    input_valid = 1'b0;
    while (!output_valid && lat < 3 * LAT) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check(tag, lat, LAT);
  endtask

  task automatic wait_drain();
    int n = 0;
    input_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    dividend     = '0;
    divisor      = '0;
    round_mode   = 1'b0;
    input_tag    = '0;
    cur_exp      = mk(0, 0, 1'b0, 0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_output_valid", output_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_output_tag", output_tag, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    send(100, 7, 1'b0, mk(14, 2, 1'b0, 1));
    measure_latency("latency");
    wait_drain();

    send(-95, 10, 1'b1, mk(-10, 5, 1'b0, 2));
    send(-95, 10, 1'b0, mk(-9, -5, 1'b0, 3));
    send(94, 10, 1'b1, mk(9, 4, 1'b0, 4));
    send(-2048, 1, 1'b1, mk(-2048, 0, 1'b0, 5));
    send(2047, 63, 1'b0, mk(32, 31, 1'b0, 6));
    send(123, 0, 1'b1, mk(0, 123, 1'b1, 7));
    send(6, 3, 1'b0, mk(2, 0, 1'b0, 8));
    wait_drain();

    stall_seen = 0;
    fork
      begin
        repeat (20) @(posedge clock);
        #1;
        output_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        output_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 40; i++) send_rand(i);
    wait_drain();
    check("stall_cycles", stall_seen, 5);

    for (int i = 40; i < 48; i++) send_rand(i);
    reset       = 1'b1;
    input_valid = 1'b0;
    sb.delete();
    @(posedge clock);
    #1;
    check("midrst_output_valid", output_valid, 0);
    check("midrst_quotient", quotient, 0);
    reset = 1'b0;
    send(-7, 2, 1'b1, mk(-4, 1, 1'b0, 48));
    measure_latency("post_reset_latency");
    wait_drain();
    repeat (30) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
